// File: rtl/demux_8x1_buffered.sv
// Registered 1-to-8 demultiplexer with valid/ready handshaking.
// Each output channel has a one-entry holding register and a full flag.
module demux_8x1_buffered #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [2:0]         selection,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [8*WIDTH-1:0] out_data,
    output logic [7:0]         out_valid,
    input  logic [7:0]         out_ready,
    output logic [3:0]         pending
);

    logic [7:0]       r_full;
    logic [WIDTH-1:0] r_buf [8];
    logic [3:0]       r_pending;

    logic             w_accept;
    logic [7:0]       w_drain;
    logic [7:0]       w_full_nxt;
    logic [3:0]       w_pending_nxt;

    // Pass-through acceptance: a full channel that drains this cycle can take a new word.
    assign in_ready = ~r_full[selection] | out_ready[selection];
    assign w_accept = in_valid & in_ready;
    assign w_drain  = r_full & out_ready;

    always_comb begin
        w_full_nxt = r_full & ~w_drain;
        if (w_accept) begin
            w_full_nxt[selection] = 1'b1;
        end
    end

    always_comb begin
        w_pending_nxt = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (w_full_nxt[i]) begin
                w_pending_nxt = w_pending_nxt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full    <= '0;
            r_pending <= '0;
        end else begin
            r_full    <= w_full_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_accept) begin
            r_buf[selection] <= in_data;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_out
        assign out_data[g*WIDTH +: WIDTH] = r_buf[g];
    end

    assign out_valid = r_full;
    assign pending   = r_pending;

endmodule

// File: tb/tb_demux_8x1_buffered.sv
// Directed-vector bench for demux_8x1_buffered with hand-computed expectations.
module tb_demux_8x1_buffered;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [2:0]  selection;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [3:0]  pending;

    int unsigned n_tests;
    int unsigned n_fail;

    demux_8x1_buffered #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .selection (selection),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 8'h00;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_data   = 8'($urandom);
        selection = 3'($urandom);
        in_valid  = 1'b1;
        out_ready = 8'($urandom);

        // Reset with random inputs
        repeat (3) tick();
        in_data   = 8'($urandom);
        out_ready = 8'($urandom);
        #1;
        check("rst_valid", {56'd0, out_valid}, 64'h0);
        check("rst_data", out_data, 64'h0);
        check("rst_pending", {60'd0, pending}, 64'h0);
        check("rst_ready", {63'd0, in_ready}, 64'h1);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", {56'd0, out_valid}, 64'h0);

        // Single route to channel 5
        in_data = 8'hA5; selection = 3'd5; in_valid = 1'b1;
        #1;
        check("route_ready", {63'd0, in_ready}, 64'h1);
        tick();
        idle();
        check("route_valid", {56'd0, out_valid}, 64'h20);
        check("route_data", {56'd0, out_data[5*8 +: 8]}, 64'hA5);
        check("route_pending", {60'd0, pending}, 64'h1);
        out_ready = 8'h20;
        tick();
        idle();
        check("drain_valid", {56'd0, out_valid}, 64'h0);
        check("drain_pending", {60'd0, pending}, 64'h0);
        check("drain_keeps_buf", {56'd0, out_data[5*8 +: 8]}, 64'hA5);

        // Full channel stall
        in_data = 8'h11; selection = 3'd2; in_valid = 1'b1;
        tick();
        in_data = 8'h99; selection = 3'd2; in_valid = 1'b1; out_ready = 8'h00;
        #1;
        check("stall_ready", {63'd0, in_ready}, 64'h0);
        tick();
        check("stall_data", {56'd0, out_data[2*8 +: 8]}, 64'h11);
        check("stall_valid", {56'd0, out_valid}, 64'h04);
        in_data = 8'h33; selection = 3'd3;
        #1;
        check("other_ready", {63'd0, in_ready}, 64'h1);
        tick();
        idle();
        check("other_valid", {56'd0, out_valid}, 64'h0C);
        check("other_data", {56'd0, out_data[3*8 +: 8]}, 64'h33);
        check("other_pending", {60'd0, pending}, 64'h2);

        // Pass-through refill of channel 2
        in_data = 8'h22; selection = 3'd2; in_valid = 1'b1; out_ready = 8'h04;
        #1;
        check("pt_ready", {63'd0, in_ready}, 64'h1);
        tick();
        idle();
        check("pt_valid", {56'd0, out_valid}, 64'h0C);
        check("pt_data", {56'd0, out_data[2*8 +: 8]}, 64'h22);
        check("pt_pending", {60'd0, pending}, 64'h2);
        out_ready = 8'hFF;
        tick();
        idle();
        check("clear_valid", {56'd0, out_valid}, 64'h0);
        check("clear_pending", {60'd0, pending}, 64'h0);

        // Fill all eight channels
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(8'h40 + i); selection = 3'(i); in_valid = 1'b1;
            tick();
            check("fill_pending", {60'd0, pending}, 64'(i + 1));
        end
        idle();
        check("fill_valid", {56'd0, out_valid}, 64'hFF);
        check("fill_data", out_data, 64'h4746454443424140);
        in_data = 8'hEE; selection = 3'd6;
        #1;
        check("fill_ready", {63'd0, in_ready}, 64'h0);
        out_ready = 8'hFF;
        tick();
        idle();
        check("drain_all_valid", {56'd0, out_valid}, 64'h0);
        check("drain_all_pending", {60'd0, pending}, 64'h0);

        // Mid-stream asynchronous reset
        in_valid = 1'b1;
        in_data = 8'h01; selection = 3'd1; tick();
        in_data = 8'h04; selection = 3'd4; tick();
        in_data = 8'h06; selection = 3'd6; tick();
        idle();
        check("pre_rst_pending", {60'd0, pending}, 64'h3);
        check("pre_rst_valid", {56'd0, out_valid}, 64'h52);
        selection = 3'd1;
        #1;
        check("pre_rst_ready", {63'd0, in_ready}, 64'h0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {56'd0, out_valid}, 64'h0);
        check("mid_rst_data", out_data, 64'h0);
        check("mid_rst_pending", {60'd0, pending}, 64'h0);
        check("mid_rst_ready", {63'd0, in_ready}, 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("after_rst_valid", {56'd0, out_valid}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
